// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The queue uses the slave modport; the fetch/decode side uses master.
interface if_id_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    // Fetch side
    logic                         in_valid;
    logic                         in_ready;
    logic [XLEN-1:0]              pc_in;
    logic [XLEN-1:0]              pc_4_in;
    logic [XLEN-1:0]              instr_in;

    // Pipeline control
    logic                         flush;
    logic                         stall;

    // Decode side
    logic                         out_valid;
    logic [XLEN-1:0]              pc_out;
    logic [XLEN-1:0]              pc_4_out;
    logic [XLEN-1:0]              instr_out;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, pc_in, pc_4_in, instr_in, flush, stall,
        input  in_ready, out_valid, pc_out, pc_4_out, instr_out, count
    );

    modport slave (
        input  in_valid, pc_in, pc_4_in, instr_in, flush, stall,
        output in_ready, out_valid, pc_out, pc_4_out, instr_out, count
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO between fetch and decode. Fetch pushes {pc, pc+4, instr}
// with valid/ready; decode pops unless stalled; flush empties the queue.
// Outputs are decoded purely from registered state (no in->out bypass).
module if_id_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h00000013)
) (
    input logic          clk,
    input logic          reset,
    if_id_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t           storage [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & ~bus.stall;

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.count     = cnt;

    // Write the fetched entry into the tail slot; a push coinciding with
    // reset or flush is dropped and must leave the slot untouched.
    // NOTE: storage carries no reset; pointers and cnt alone define which
    // slots are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && push) begin
            storage[wr_ptr] <= '{pc: bus.pc_in, pc_4: bus.pc_4_in, instr: bus.instr_in};
        end
    end

    // Pointer and occupancy update: reset > flush > push/pop.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head entry to decode; an empty queue presents a NOP with zero pcs.
    // NOTE: defaults first so every path assigns every output (no latch).
    always_comb begin
        bus.pc_out    = '0;
        bus.pc_4_out  = '0;
        bus.instr_out = NOP_INSN;
        if (!empty) begin
            bus.pc_out    = storage[rd_ptr].pc;
            bus.pc_4_out  = storage[rd_ptr].pc_4;
            bus.instr_out = storage[rd_ptr].instr;
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. Two instances (DEPTH=2 and DEPTH=4)
// share identical stimulus; each is compared every cycle against its own
// queue-based reference model, plus directed spot checks.
module tb_if_id_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] pc_in;
    logic [31:0] pc_4_in;
    logic [31:0] instr_in;
    logic        flush;
    logic        stall;

    int tests  = 0;
    int failed = 0;

    entry_t model2[$];
    entry_t model4[$];

    always #5 clk = ~clk;

    if_id_queue_if #(.XLEN(32), .DEPTH(2)) bus2 ();
    if_id_queue_if #(.XLEN(32), .DEPTH(4)) bus4 ();

    assign bus2.in_valid = in_valid;
    assign bus2.pc_in    = pc_in;
    assign bus2.pc_4_in  = pc_4_in;
    assign bus2.instr_in = instr_in;
    assign bus2.flush    = flush;
    assign bus2.stall    = stall;
    assign bus4.in_valid = in_valid;
    assign bus4.pc_in    = pc_in;
    assign bus4.pc_4_in  = pc_4_in;
    assign bus4.instr_in = instr_in;
    assign bus4.flush    = flush;
    assign bus4.stall    = stall;

    if_id_queue #(.XLEN(32), .DEPTH(2), .NOP_INSN(NOP)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    if_id_queue #(.XLEN(32), .DEPTH(4), .NOP_INSN(NOP)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare one instance against its model queue.
    task automatic compare(input string name, input int depth, input entry_t q[$],
                           input logic ov, input logic ir, input logic [31:0] cnt,
                           input logic [31:0] pc, input logic [31:0] pc4,
                           input logic [31:0] ins);
        logic [31:0] e_pc, e_pc4, e_ins;
        e_pc  = 32'h0;
        e_pc4 = 32'h0;
        e_ins = NOP;
        if (q.size() != 0) begin
            e_pc  = q[0].pc;
            e_pc4 = q[0].pc_4;
            e_ins = q[0].instr;
        end
        chk({name, ".out_valid"}, 32'(ov), 32'(q.size() != 0));
        chk({name, ".in_ready"},  32'(ir), 32'(q.size() != depth));
        chk({name, ".count"},     cnt, 32'(q.size()));
        chk({name, ".pc_out"},    pc, e_pc);
        chk({name, ".pc_4_out"},  pc4, e_pc4);
        chk({name, ".instr_out"}, ins, e_ins);
    endtask

    task automatic check_all();
        compare("d2", 2, model2, bus2.out_valid, bus2.in_ready, 32'(bus2.count),
                bus2.pc_out, bus2.pc_4_out, bus2.instr_out);
        compare("d4", 4, model4, bus4.out_valid, bus4.in_ready, 32'(bus4.count),
                bus4.pc_out, bus4.pc_4_out, bus4.instr_out);
    endtask

    // Reference behaviour: a bounded FIFO of entries.
    task automatic update_model(inout entry_t q[$], input int depth);
        bit do_push;
        bit do_pop;
        entry_t e;
        do_push = in_valid && (q.size() < depth);
        do_pop  = (q.size() > 0) && !stall;
        e.pc    = pc_in;
        e.pc_4  = pc_4_in;
        e.instr = instr_in;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        update_model(model2, 2);
        update_model(model4, 4);
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit st, input bit fl, input bit rs);
        in_valid = v;
        pc_in    = pc;
        pc_4_in  = pc + 32'd4;
        instr_in = ins;
        stall    = st;
        flush    = fl;
        reset    = rs;
    endtask

    initial begin
        // Reset held two cycles while fetch offers an entry.
        drive(1, 32'h100, 32'hDEAD0000, 0, 0, 1);
        step();
        step();
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        step();
        chk("reset.out_valid", 32'(bus2.out_valid), 32'd0);
        chk("reset.instr_out", bus2.instr_out, NOP);
        chk("reset.pc_out",    bus2.pc_out, 32'h0);
        chk("reset.count",     32'(bus2.count), 32'd0);
        chk("reset.in_ready",  32'(bus2.in_ready), 32'd1);

        // Fill under stall, third push refused by DEPTH=2, then drain.
        drive(1, 32'h0, 32'hAAAA0001, 1, 0, 0);
        step();
        drive(1, 32'h4, 32'hAAAA0002, 1, 0, 0);
        step();
        chk("fill.count",    32'(bus2.count), 32'd2);
        chk("fill.in_ready", 32'(bus2.in_ready), 32'd0);
        drive(1, 32'h8, 32'hAAAA0003, 1, 0, 0);
        step();
        chk("fill.ignored.count", 32'(bus2.count), 32'd2);
        chk("fill.head",          bus2.pc_out, 32'h0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        step();
        chk("drain.pc1", bus2.pc_out, 32'h4);
        chk("drain.instr1", bus2.instr_out, 32'hAAAA0002);
        step();
        chk("drain.empty", 32'(bus2.out_valid), 32'd0);
        step();

        // Streaming: one push per cycle, no stall, across pointer wrap.
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'(i * 4), 32'hB0000000 | 32'(i), 0, 0, 0);
            step();
            chk("stream.count2", 32'(bus2.count), 32'd1);
            chk("stream.count4", 32'(bus4.count), 32'd1);
            chk("stream.pc2",    bus2.pc_out, 32'(i * 4));
        end
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        step();

        // Flush with a simultaneous push: entry 0x40 must never appear.
        drive(1, 32'h10, 32'hC0000001, 1, 0, 0);
        step();
        drive(1, 32'h14, 32'hC0000002, 1, 0, 0);
        step();
        chk("flush.pre.count", 32'(bus2.count), 32'd2);
        drive(1, 32'h40, 32'hC0000040, 1, 1, 0);
        step();
        chk("flush.count",     32'(bus2.count), 32'd0);
        chk("flush.out_valid", 32'(bus4.out_valid), 32'd0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        step();
        step();

        // Simultaneous push and pop at DEPTH-1 on the DEPTH=4 instance.
        drive(1, 32'h20, 32'hD0000001, 1, 0, 0);
        step();
        drive(1, 32'h24, 32'hD0000002, 1, 0, 0);
        step();
        drive(1, 32'h28, 32'hD0000003, 1, 0, 0);
        step();
        chk("pp.pre.count4", 32'(bus4.count), 32'd3);
        drive(1, 32'h2C, 32'hD0000004, 0, 0, 0);
        step();
        chk("pp.count4", 32'(bus4.count), 32'd3);
        chk("pp.head4",  bus4.pc_out, 32'h24);
        drive(0, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        // Reset together with flush while full and stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h30 + 32'(i * 4), 32'hE0000000 | 32'(i), 1, 0, 0);
            step();
        end
        chk("full.count4", 32'(bus4.count), 32'd4);
        drive(1, 32'h50, 32'hE00000FF, 1, 1, 1);
        step();
        chk("rst_mid.count4",    32'(bus4.count), 32'd0);
        chk("rst_mid.in_ready4", 32'(bus4.in_ready), 32'd1);
        chk("rst_mid.instr4",    bus4.instr_out, NOP);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 49) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
